// File: rtl/mips_bus_lsu.sv
// Load/store unit bridging the multicycle MIPS core to an Avalon-MM master port.
// One access at a time: lane steering, waitrequest handshake, optional timeout.
module mips_bus_lsu #(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_WIDTH      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t               state, state_nx;
    logic                 write_l;
    logic [1:0]           size_l;
    logic                 signed_l;
    logic [31:0]          addr_l;
    logic [31:0]          wdata_l;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 timeout_hit;
    logic                 bad_req;

    function automatic logic [3:0] lane_be(input logic [1:0] sz,
                                           input logic [1:0] off);
        logic [3:0] be;
        be = 4'b1111;
        case (sz)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wd(input logic [1:0]  sz,
                                            input logic [31:0] d);
        logic [31:0] w;
        w = d;
        case (sz)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] d,
                                             input logic [1:0]  sz,
                                             input logic [1:0]  off,
                                             input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = d[7:0];
        case (off)
            2'd0: b = d[7:0];
            2'd1: b = d[15:8];
            2'd2: b = d[23:16];
            2'd3: b = d[31:24];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (sz)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = d;
        endcase
        return r;
    endfunction

    assign bad_req = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    assign cnt_inc     = cnt + CNT_WIDTH'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (cnt_inc == CNT_WIDTH'(TIMEOUT_CYCLES));

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        byteenable = '0;
        writedata  = '0;
        case (state)
            IDLE: begin
                req_ready = !reset;
                if (req_valid)
                    state_nx = bad_req ? RESP : BUS;
            end
            BUS: begin
                read       = !write_l;
                write      = write_l;
                address    = {addr_l[31:2], 2'b00};
                byteenable = lane_be(size_l, addr_l[1:0]);
                writedata  = lane_wd(size_l, wdata_l);
                if (!waitrequest || timeout_hit)
                    state_nx = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            write_l    <= 1'b0;
            size_l     <= 2'b00;
            signed_l   <= 1'b0;
            addr_l     <= '0;
            wdata_l    <= '0;
            cnt        <= '0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (req_valid) begin
                    write_l  <= req_write;
                    size_l   <= req_size;
                    signed_l <= req_signed;
                    addr_l   <= req_addr;
                    wdata_l  <= req_wdata;
                    cnt      <= '0;
                    if (bad_req) begin
                        resp_error <= 1'b1;
                        resp_rdata <= '0;
                    end
                end
                BUS: begin
                    if (!waitrequest) begin
                        resp_error <= 1'b0;
                        resp_rdata <= write_l ? 32'd0 :
                            load_ext(readdata, size_l, addr_l[1:0], signed_l);
                    end else begin
                        cnt <= cnt_inc;
                        // Abort: result is an error with no data
                        if (timeout_hit) begin
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
